// File: rtl/csi_lane_aligner.sv
// Deskews NUM_LANE CSI byte lanes: measures first-byte arrival offsets at burst start, then
// delays the early lanes so one aligned word of NUM_LANE bytes is presented per cycle.
module csi_lane_aligner #(
    parameter int NUM_LANE = 2,
    parameter int MAX_SKEW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_LANE-1:0]   byte_vld_i,
    input  logic [NUM_LANE*8-1:0] byte_i,
    input  logic                  pkt_done_i,
    output logic                  word_vld_o,
    output logic [NUM_LANE*8-1:0] word_o,
    output logic                  aligned_o,
    output logic                  align_err_o
);
    localparam int CW = $clog2(MAX_SKEW + 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitAll = 2'd1;
    localparam logic [1:0] StAligned = 2'd2;
    localparam logic [1:0] StDrain   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_LANE-1:0]   seen_q, seen_nxt;
    logic [CW-1:0]         arr_q     [NUM_LANE];
    logic [CW-1:0]         arr_nxt   [NUM_LANE];
    logic [CW-1:0]         delay_q   [NUM_LANE];
    logic [CW-1:0]         delay_nxt [NUM_LANE];
    logic [CW-1:0]         delay_eff [NUM_LANE];
    logic [CW-1:0]         max_arr;
    logic                  all_seen;
    // Together with the live input this gives a MAX_SKEW+1 deep window per lane.
    logic [7:0]            hist_data_q [NUM_LANE][MAX_SKEW];
    logic                  hist_vld_q  [NUM_LANE][MAX_SKEW];
    logic [NUM_LANE*8-1:0] dly_data;
    logic [NUM_LANE-1:0]   dly_vld;
    logic                  load, err, word_vld_d;
    logic                  word_vld_q;
    logic [NUM_LANE*8-1:0] word_q;

    // Arrival bookkeeping including lanes arriving this cycle, so completion needs no extra cycle.
    always_comb begin
        seen_nxt = seen_q;
        for (int l = 0; l < NUM_LANE; l++) arr_nxt[l] = arr_q[l];
        if (state_q == StIdle) begin
            seen_nxt = byte_vld_i;
            for (int l = 0; l < NUM_LANE; l++) arr_nxt[l] = '0;
        end else if (state_q == StWaitAll) begin
            for (int l = 0; l < NUM_LANE; l++) begin
                if (byte_vld_i[l] && !seen_q[l]) begin
                    seen_nxt[l] = 1'b1;
                    arr_nxt[l]  = cnt_q;
                end
            end
        end
        all_seen = &seen_nxt;
        max_arr  = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            if (arr_nxt[l] > max_arr) max_arr = arr_nxt[l];
        end
        for (int l = 0; l < NUM_LANE; l++) delay_nxt[l] = max_arr - arr_nxt[l];
    end

    always_comb begin
        for (int l = 0; l < NUM_LANE; l++) begin
            delay_eff[l] = (state_q == StAligned) ? delay_q[l] : delay_nxt[l];
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANE; l++) begin
            dly_data[l*8 +: 8] = byte_i[l*8 +: 8];
            dly_vld[l]         = byte_vld_i[l];
            for (int k = 1; k <= MAX_SKEW; k++) begin
                if (delay_eff[l] == CW'(k)) begin
                    dly_data[l*8 +: 8] = hist_data_q[l][k-1];
                    dly_vld[l]         = hist_vld_q[l][k-1];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        err     = 1'b0;
        case (state_q)
            StIdle: begin
                if (|byte_vld_i) begin
                    cnt_d = CW'(1);
                    if (all_seen) begin
                        state_d = StAligned;
                        load    = 1'b1;
                    end else begin
                        state_d = StWaitAll;
                    end
                end
            end
            StWaitAll: begin
                cnt_d = cnt_q + CW'(1);
                if (all_seen) begin
                    state_d = StAligned;
                    load    = 1'b1;
                end else if (cnt_q == CW'(MAX_SKEW)) begin
                    err     = 1'b1;
                    state_d = StDrain;
                end
            end
            StAligned: begin
                load = 1'b1;
                if (!(&dly_vld)) state_d = StDrain;
            end
            StDrain: begin
                if (!(|byte_vld_i)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (pkt_done_i) begin
            state_d = StDrain;
            load    = 1'b0;
            err     = 1'b0;
        end
        word_vld_d = load & (&dly_vld);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            seen_q     <= '0;
            word_vld_q <= 1'b0;
            word_q     <= '0;
            for (int l = 0; l < NUM_LANE; l++) begin
                arr_q[l]   <= '0;
                delay_q[l] <= '0;
                for (int k = 0; k < MAX_SKEW; k++) begin
                    hist_data_q[l][k] <= '0;
                    hist_vld_q[l][k]  <= 1'b0;
                end
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_nxt;
            word_vld_q <= word_vld_d;
            if (word_vld_d) word_q <= dly_data;
            for (int l = 0; l < NUM_LANE; l++) begin
                arr_q[l]          <= arr_nxt[l];
                delay_q[l]        <= delay_eff[l];
                hist_data_q[l][0] <= byte_i[l*8 +: 8];
                hist_vld_q[l][0]  <= byte_vld_i[l];
                for (int k = 1; k < MAX_SKEW; k++) begin
                    hist_data_q[l][k] <= hist_data_q[l][k-1];
                    hist_vld_q[l][k]  <= hist_vld_q[l][k-1];
                end
            end
        end
    end

    assign word_vld_o  = word_vld_q;
    assign word_o      = word_q;
    assign aligned_o   = (state_q == StAligned);
    assign align_err_o = err & ~reset;

endmodule

// File: tb/tb_csi_lane_aligner.sv
// Bench for csi_lane_aligner: 4-lane vector table, 2-lane corner sequences, and 2-lane random
// bursts checked against an absolute-time reference model.
module tb_csi_lane_aligner;
    localparam int MAX_SKEW = 4;
    localparam int HN       = 8192;
    localparam int MIdle = 0, MWait = 1, MAligned = 2, MDrain = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, pd2, wv2, al2, err2;
    logic [1:0]  vld2;
    logic [15:0] byte2, w2;
    logic        rst4, pd4, wv4, al4, err4;
    logic [3:0]  vld4;
    logic [31:0] byte4, w4;

    csi_lane_aligner #(.NUM_LANE(2), .MAX_SKEW(MAX_SKEW)) u_dut2 (
        .clk(clk), .reset(rst2), .byte_vld_i(vld2), .byte_i(byte2), .pkt_done_i(pd2),
        .word_vld_o(wv2), .word_o(w2), .aligned_o(al2), .align_err_o(err2)
    );

    csi_lane_aligner #(.NUM_LANE(4), .MAX_SKEW(4)) u_dut4 (
        .clk(clk), .reset(rst4), .byte_vld_i(vld4), .byte_i(byte4), .pkt_done_i(pd4),
        .word_vld_o(wv4), .word_o(w4), .aligned_o(al4), .align_err_o(err4)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic        s_vld, s_al, s_err;
    logic [15:0] s_word;

    // Reference model state: burst timing kept as absolute cycle numbers.
    logic [7:0]  hb [2][HN];
    logic        hv [2][HN];
    int          cyc;
    int          m_state, m_t0, m_last;
    int          m_first [2];
    logic        m_vld;
    logic [15:0] m_word;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] b;
        logic        ev;
        logic [31:0] ew;
        logic        ea;
    } vec4_t;
    vec4_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = MIdle;
        m_vld   = 1'b0;
        m_word  = '0;
        m_t0    = 0;
        m_last  = 0;
        m_first[0] = -1;
        m_first[1] = -1;
    endtask

    task automatic model_step(input logic [1:0] v, input logic [15:0] b, input logic pd,
                              input logic rst, output logic e_err);
        int          ns, idx;
        logic        nv, emit, allv;
        logic [15:0] nw, word;
        for (int l = 0; l < 2; l++) begin
            hb[l][cyc] = b[l*8 +: 8];
            hv[l][cyc] = v[l];
        end
        e_err = 1'b0;
        ns    = m_state;
        nv    = 1'b0;
        nw    = m_word;
        emit  = 1'b0;
        case (m_state)
            MIdle: if (v != 2'b00) begin
                m_t0 = cyc;
                for (int l = 0; l < 2; l++) m_first[l] = v[l] ? cyc : -1;
                if (v == 2'b11) begin
                    m_last = cyc;
                    ns     = MAligned;
                    emit   = 1'b1;
                end else ns = MWait;
            end
            MWait: begin
                for (int l = 0; l < 2; l++) if (m_first[l] < 0 && v[l]) m_first[l] = cyc;
                if (m_first[0] >= 0 && m_first[1] >= 0) begin
                    m_last = cyc;
                    ns     = MAligned;
                    emit   = 1'b1;
                end else if (cyc - m_t0 == MAX_SKEW) begin
                    e_err = 1'b1;
                    ns    = MDrain;
                end
            end
            MAligned: emit = 1'b1;
            default: if (v == 2'b00) ns = MIdle;
        endcase
        if (emit) begin
            allv = 1'b1;
            word = '0;
            for (int l = 0; l < 2; l++) begin
                idx  = cyc - (m_last - m_first[l]);
                allv = allv & hv[l][idx];
                word[l*8 +: 8] = hb[l][idx];
            end
            if (allv) begin
                nv = 1'b1;
                nw = word;
            end else ns = MDrain;
        end
        if (pd) begin
            ns    = MDrain;
            nv    = 1'b0;
            nw    = m_word;
            e_err = 1'b0;
        end
        if (rst) begin
            ns    = MIdle;
            nv    = 1'b0;
            nw    = '0;
            e_err = 1'b0;
        end
        m_state = ns;
        m_vld   = nv;
        m_word  = nw;
        cyc++;
    endtask

    // One 2-lane cycle: drive, sample at negedge, compare against the model, advance.
    task automatic step(input logic [1:0] v, input logic [15:0] b, input logic pd,
                        input logic rst);
        logic e_err;
        vld2  = v;
        byte2 = b;
        pd2   = pd;
        rst2  = rst;
        @(negedge clk);
        s_vld  = wv2;
        s_word = w2;
        s_al   = al2;
        s_err  = err2;
        chk("m_word_vld", 32'(s_vld), 32'(m_vld));
        chk("m_word", 32'(s_word), 32'(m_word));
        chk("m_aligned", 32'(s_al), 32'(m_state == MAligned));
        model_step(v, b, pd, rst, e_err);
        chk("m_align_err", 32'(s_err), 32'(e_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         o0, o1, len, gap, tot;
        logic [1:0] v;

        // Lane offsets {0,3,1,2}: lane l byte k is B8 for k=0, else 8'h(l+1)k.
        tbl[0] = '{4'b0001, 32'h000000B8, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{4'b0101, 32'h00B80011, 1'b0, 32'h0,        1'b0};
        tbl[2] = '{4'b1101, 32'hB8310012, 1'b0, 32'h0,        1'b0};
        tbl[3] = '{4'b1111, 32'h4132B813, 1'b0, 32'h0,        1'b0};
        tbl[4] = '{4'b1110, 32'h42332100, 1'b1, 32'hB8B8B8B8, 1'b1};
        tbl[5] = '{4'b1010, 32'h43002200, 1'b1, 32'h41312111, 1'b1};
        tbl[6] = '{4'b0010, 32'h00002300, 1'b1, 32'h42322212, 1'b1};
        tbl[7] = '{4'b0000, 32'h00000000, 1'b1, 32'h43332313, 1'b1};
        tbl[8] = '{4'b0000, 32'h00000000, 1'b0, 32'h43332313, 1'b0};
        tbl[9] = '{4'b0000, 32'h00000000, 1'b0, 32'h43332313, 1'b0};

        vld2 = '0; byte2 = '0; pd2 = 1'b0; rst2 = 1'b1;
        vld4 = '0; byte4 = '0; pd4 = 1'b0; rst4 = 1'b1;
        cyc  = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        rst4 = 1'b0;

        @(negedge clk);
        chk("rst_vld2", 32'(wv2), 32'd0);
        chk("rst_word2", 32'(w2), 32'd0);
        chk("rst_aligned2", 32'(al2), 32'd0);
        chk("rst_err2", 32'(err2), 32'd0);
        chk("rst_vld4", 32'(wv4), 32'd0);
        chk("rst_word4", w4, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            vld4  = tbl[i].v;
            byte4 = tbl[i].b;
            @(negedge clk);
            chk($sformatf("t4_vld[%0d]", i), 32'(wv4), 32'(tbl[i].ev));
            chk($sformatf("t4_word[%0d]", i), w4, tbl[i].ew);
            chk($sformatf("t4_aligned[%0d]", i), 32'(al4), 32'(tbl[i].ea));
            chk($sformatf("t4_err[%0d]", i), 32'(err4), 32'd0);
            @(posedge clk);
            #1;
        end

        // Zero skew
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        step(2'b11, 16'hB8B8, 1'b0, 1'b0);
        step(2'b11, 16'h0201, 1'b0, 1'b0);
        chk("zs_first_vld", 32'(s_vld), 32'd1);
        chk("zs_first_word", 32'(s_word), 32'hB8B8);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        chk("zs_second_word", 32'(s_word), 32'h0201);
        chk("zs_err", 32'(s_err), 32'd0);
        repeat (3) step(2'b00, 16'h0000, 1'b0, 1'b0);

        // Skew of 2 cycles, lane0 early
        step(2'b01, 16'h00B8, 1'b0, 1'b0);
        step(2'b01, 16'h0001, 1'b0, 1'b0);
        step(2'b11, 16'hB802, 1'b0, 1'b0);
        step(2'b11, 16'h0103, 1'b0, 1'b0);
        chk("sk2_first_vld", 32'(s_vld), 32'd1);
        chk("sk2_first_word", 32'(s_word), 32'hB8B8);
        chk("sk2_aligned", 32'(s_al), 32'd1);
        step(2'b11, 16'h0204, 1'b0, 1'b0);
        chk("sk2_word1", 32'(s_word), 32'h0101);
        step(2'b10, 16'h0300, 1'b0, 1'b0);
        chk("sk2_word2", 32'(s_word), 32'h0202);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        chk("sk2_word3", 32'(s_word), 32'h0303);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        chk("sk2_drop_vld", 32'(s_vld), 32'd0);
        repeat (3) step(2'b00, 16'h0000, 1'b0, 1'b0);

        // Skew overflow: lane1 never arrives
        step(2'b01, 16'h00B8, 1'b0, 1'b0);
        repeat (3) step(2'b01, 16'h0055, 1'b0, 1'b0);
        chk("ovf_no_early_err", 32'(s_err), 32'd0);
        step(2'b01, 16'h0055, 1'b0, 1'b0);
        chk("ovf_err", 32'(s_err), 32'd1);
        chk("ovf_vld", 32'(s_vld), 32'd0);
        step(2'b01, 16'h0055, 1'b0, 1'b0);
        chk("ovf_err_pulse", 32'(s_err), 32'd0);
        chk("ovf_not_aligned", 32'(s_al), 32'd0);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        step(2'b11, 16'hB8B8, 1'b0, 1'b0);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        chk("ovf_restart_vld", 32'(s_vld), 32'd1);
        chk("ovf_restart_word", 32'(s_word), 32'hB8B8);
        repeat (3) step(2'b00, 16'h0000, 1'b0, 1'b0);

        // pkt_done mid-burst while lanes stay valid
        step(2'b11, 16'h1111, 1'b0, 1'b0);
        step(2'b11, 16'h2222, 1'b0, 1'b0);
        step(2'b11, 16'h3333, 1'b1, 1'b0);
        chk("pd_before_vld", 32'(s_vld), 32'd1);
        step(2'b11, 16'h4444, 1'b0, 1'b0);
        chk("pd_vld_off", 32'(s_vld), 32'd0);
        chk("pd_word_hold", 32'(s_word), 32'h2222);
        step(2'b11, 16'h5555, 1'b0, 1'b0);
        chk("pd_still_off", 32'(s_vld), 32'd0);
        chk("pd_not_aligned", 32'(s_al), 32'd0);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        step(2'b11, 16'hB8B8, 1'b0, 1'b0);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        chk("pd_new_burst", 32'(s_vld), 32'd1);
        repeat (3) step(2'b00, 16'h0000, 1'b0, 1'b0);

        // Reset mid-burst, then a skew-1 burst
        step(2'b11, 16'hB8B8, 1'b0, 1'b0);
        step(2'b11, 16'h0101, 1'b0, 1'b0);
        step(2'b11, 16'h0202, 1'b0, 1'b1);
        chk("rb_pre_vld", 32'(s_vld), 32'd1);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        chk("rb_vld", 32'(s_vld), 32'd0);
        chk("rb_word", 32'(s_word), 32'd0);
        chk("rb_aligned", 32'(s_al), 32'd0);
        step(2'b01, 16'h00B8, 1'b0, 1'b0);
        step(2'b11, 16'hB801, 1'b0, 1'b0);
        step(2'b11, 16'h0102, 1'b0, 1'b0);
        chk("rb_first_word", 32'(s_word), 32'hB8B8);
        chk("rb_first_vld", 32'(s_vld), 32'd1);
        step(2'b00, 16'h0000, 1'b0, 1'b0);
        chk("rb_word1", 32'(s_word), 32'h0101);
        repeat (3) step(2'b00, 16'h0000, 1'b0, 1'b0);

        // Random bursts with occasional pkt_done and reset
        for (int bst = 0; bst < 80; bst++) begin
            o0  = int'($urandom_range(0, 5));
            o1  = int'($urandom_range(0, 5));
            len = int'($urandom_range(1, 8));
            gap = int'($urandom_range(1, 3));
            tot = ((o0 > o1) ? o0 : o1) + len + gap;
            for (int i = 0; i < tot; i++) begin
                v[0] = (i >= o0) && (i < o0 + len);
                v[1] = (i >= o1) && (i < o1 + len);
                step(v, 16'($urandom()), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 79) == 0));
            end
        end
        repeat (4) step(2'b00, 16'h0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
